dmem_minibus_master: RTL and testbench
======================================

# dmem_minibus_master

Data-memory bus master that turns single CPU load/store requests into minibus transactions toward on-chip slaves such as the RAM slave. It holds each request stable until the slave acks, errors, or times out. It then returns aligned, sign- or zero-extended load data and an error flag to the CPU. The block sits between the CPU memory stage and the minibus; the RAM slave is its direct downstream neighbour.

## Interface
- TIMEOUT_CYCLES, 16: maximum REQ cycles without ack or err before the block reports a bus error (range 2..255).
- clk  in  1  system clock; all state changes on its rising edge
- rst  in  1  synchronous, active-high reset
- cpu_req_valid  in  1  request present
- cpu_req_ready  out  1  request accepted this cycle when valid&ready
- cpu_req_wen  in  1  1 = store, 0 = load
- cpu_req_addr  in  32  byte address
- cpu_req_wdata  in  32  store data, right-aligned
- cpu_req_width  in  3  RV funct3: [1:0] 00 byte, 01 half, 10 word; [2] 1 = unsigned load
- cpu_rsp_valid  out  1  one-cycle response pulse
- cpu_rsp_rdata  out  32  extended load data (0 for stores and errors)
- cpu_rsp_err  out  1  misaligned, bus error or timeout
- bus_addr  out  32  minibus request address
- bus_wdata  out  32  lane-replicated write data
- bus_wen / bus_ren  out  1 each  write / read strobe
- bus_width  out  2  minibus width code
- bus_sel  out  1  slave select
- bus_ack  in  1  slave acknowledge
- bus_err  in  1  slave error
- bus_rdata  in  32  raw 32-bit word from the slave

## Operation
- States: IDLE, REQ, RESP.
- A request is accepted when valid && ready. Ready = (state is IDLE or RESP).
- On acceptance the block latches addr, wen, wdata and width.
- Misaligned request (half with addr[0]=1, word with addr[1:0]≠0, or width[1:0]=11):
  - no bus activity occurs;
  - next state is RESP with err=1.
- Aligned request: next state is REQ.
- REQ drives:
  - bus_sel=1;
  - bus_wen=wen, bus_ren=!wen;
  - bus_addr = latched addr, bus_width = width[1:0];
  - bus_wdata = byte replicated ×4 for byte, half replicated ×2 for half, word unchanged.
- REQ exits (priority err > ack > timeout):
  - bus_err → RESP, err=1;
  - bus_ack → RESP, err=0; for loads, latch the extracted data;
  - timeout counter == TIMEOUT_CYCLES−1 → RESP, err=1.
- Load extraction:
  - shift bus_rdata right by 8×addr[1:0];
  - keep 8 or 16 bits;
  - sign-extend, or zero-extend when width[2]=1;
  - word loads pass through unchanged.
- RESP: cpu_rsp_valid=1, all bus outputs 0. Next state is REQ or RESP for a newly accepted request, otherwise IDLE.
- Timeout counter clears on entry to REQ and increments each REQ cycle.

## Timing
- Reset:
  - state=IDLE;
  - every output 0 except cpu_req_ready=1;
  - latched registers and counter cleared.
- A reset asserted mid-transaction drops strobes on the next edge. No response is issued for the aborted request.
- In all non-REQ states, bus_sel, bus_wen and bus_ren are 0. This gap of at least one strobe-free cycle clears a slave's ready flag, so a held strobe never produces a duplicate ack.
- Bus outputs are registered-state-driven and stable for the whole of REQ.
- Accept at edge E0 against a one-wait slave (ack in the cycle after the first strobe cycle):
  - strobes visible after E0;
  - ack sampled at E2;
  - cpu_rsp_valid high in the cycle after E2.
  - Back-to-back throughput: 1 request per 3 cycles.
- Misaligned request: rsp_valid in the cycle after the accept edge.
- Ack and err in the same cycle: err wins. Ack in the cycle timeout fires: ack wins.
- cpu_rsp_rdata and cpu_rsp_err are valid only while cpu_rsp_valid=1 and are 0 otherwise.

## Structure
- rv32ima_pkg gains:
  - minibus width codes (BUS_BYTE=2'b00, BUS_HALF=2'b01, BUS_WORD=2'b10);
  - the state enum dmem_mst_state_t.
- One combinational sub-module, dmem_lane_align. It holds store replication and load extract/extend so the load-store unit can reuse it.
- The FSM, request latch and timeout counter stay in the top module.

## Test plan
- Load word, addr 0x00000104, slave acks 1 cycle after strobe, rdata 0xDEADBEEF → rsp_valid 3 cycles after accept, rdata 0xDEADBEEF, err 0.
- Store byte 0x5A at addr 0x203 → bus_wdata 0x5A5A5A5A, bus_width 00, bus_wen held until ack, then exactly one RESP pulse; byte 3 of RAM word updated.
- Load byte at addr 0x2, rdata 0x00807F00, width 000 then 100 → rdata 0xFFFFFF80, then 0x00000080.
- Load half at addr 0x1 → no bus_sel asserted, rsp_valid next cycle with err=1.
- Slave never acks, TIMEOUT_CYCLES=4 → 4 REQ cycles, then RESP with err=1 and strobes 0.
- Assert rst during REQ → next cycle all bus outputs 0, ready=1, no rsp_valid; a following request completes normally.

Source files
------------

// File: rtl/rv32ima_pkg.sv
// Shared types and helpers for the data-memory path.
// Provides the minibus width codes, the dmem bus master state enum and
// an alignment check used when a CPU request is accepted.
package rv32ima_pkg;

  localparam logic [1:0] BUS_BYTE = 2'b00;
  localparam logic [1:0] BUS_HALF = 2'b01;
  localparam logic [1:0] BUS_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    RESP = 2'b10
  } dmem_mst_state_t;

  // Width code 2'b11 has no minibus encoding and is treated as misaligned.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic bad;
    case (size)
      BUS_BYTE: bad = 1'b0;
      BUS_HALF: bad = addr_lo[0];
      BUS_WORD: bad = (addr_lo != 2'b00);
      default:  bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane alignment shared by the bus master and the LSU.
// Ports:
//   width    in  3   RV funct3 ([1:0] size, [2] unsigned load)
//   addr_lo  in  2   byte offset within the word
//   st_data  in  32  right-aligned store data
//   ld_raw   in  32  raw word returned by the slave
//   st_rep   out 32  store data replicated across all lanes of its size
//   ld_ext   out 32  load data shifted down and sign/zero extended
module dmem_lane_align
  import rv32ima_pkg::*;
(
  input  logic [2:0]  width,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_raw,
  output logic [31:0] st_rep,
  output logic [31:0] ld_ext
);

  logic [31:0] shifted;
  logic        sext;

  always_comb begin
    st_rep = st_data;
    case (width[1:0])
      BUS_BYTE: st_rep = {4{st_data[7:0]}};
      BUS_HALF: st_rep = {2{st_data[15:0]}};
      default:  st_rep = st_data;
    endcase
  end

  always_comb begin
    shifted = ld_raw >> {addr_lo, 3'b000};
    sext    = ~width[2];
    ld_ext  = shifted;
    case (width[1:0])
      BUS_BYTE: ld_ext = {{24{sext & shifted[7]}}, shifted[7:0]};
      BUS_HALF: ld_ext = {{16{sext & shifted[15]}}, shifted[15:0]};
      default:  ld_ext = ld_raw;
    endcase
  end

endmodule

// File: rtl/dmem_minibus_master.sv
// Data-memory minibus master: converts one CPU load/store at a time into a
// minibus transaction, holds it until ack, error or timeout, and returns
// extended load data plus an error flag as a one-cycle response.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cpu_req_*                     CPU request handshake and payload
//   cpu_rsp_valid/rdata/err       one-cycle response
//   bus_addr/wdata/wen/ren/width/sel   minibus request (REQ state only)
//   bus_ack/bus_err/bus_rdata     minibus slave response
module dmem_minibus_master
  import rv32ima_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req_valid,
  output logic        cpu_req_ready,
  input  logic        cpu_req_wen,
  input  logic [31:0] cpu_req_addr,
  input  logic [31:0] cpu_req_wdata,
  input  logic [2:0]  cpu_req_width,
  output logic        cpu_rsp_valid,
  output logic [31:0] cpu_rsp_rdata,
  output logic        cpu_rsp_err,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_wen,
  output logic        bus_ren,
  output logic [1:0]  bus_width,
  output logic        bus_sel,
  input  logic        bus_ack,
  input  logic        bus_err,
  input  logic [31:0] bus_rdata
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  dmem_mst_state_t state_q, state_d;

  logic [31:0] req_addr_q;
  logic        req_wen_q;
  logic [31:0] req_wdata_q;
  logic [2:0]  req_width_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;
  logic [7:0]  tmo_cnt_q;

  logic        accept;
  logic        misaligned;
  logic        in_req;
  logic        tmo_hit;
  logic [31:0] st_rep;
  logic [31:0] ld_ext;

  dmem_lane_align u_align (
    .width   (req_width_q),
    .addr_lo (req_addr_q[1:0]),
    .st_data (req_wdata_q),
    .ld_raw  (bus_rdata),
    .st_rep  (st_rep),
    .ld_ext  (ld_ext)
  );

  assign in_req        = (state_q == REQ);
  assign cpu_req_ready = !in_req;
  assign accept        = cpu_req_valid && cpu_req_ready;
  assign misaligned    = is_misaligned(cpu_req_width[1:0], cpu_req_addr[1:0]);
  assign tmo_hit       = (tmo_cnt_q == TMO_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, RESP: begin
        if (accept)               state_d = misaligned ? RESP : REQ;
        else if (state_q == RESP) state_d = IDLE;
      end
      REQ: begin
        if (bus_err || bus_ack || tmo_hit) state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      req_addr_q  <= '0;
      req_wen_q   <= 1'b0;
      req_wdata_q <= '0;
      req_width_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      tmo_cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_addr_q  <= cpu_req_addr;
        req_wen_q   <= cpu_req_wen;
        req_wdata_q <= cpu_req_wdata;
        req_width_q <= cpu_req_width;
        tmo_cnt_q   <= '0;
        if (misaligned) begin
          rsp_err_q   <= 1'b1;
          rsp_rdata_q <= '0;
        end
      end else if (in_req) begin
        tmo_cnt_q <= tmo_cnt_q + 8'd1;
        // err beats ack; an ack in the timeout cycle still completes normally
        if (bus_err) begin
          rsp_err_q   <= 1'b1;
          rsp_rdata_q <= '0;
        end else if (bus_ack) begin
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= req_wen_q ? 32'd0 : ld_ext;
        end else if (tmo_hit) begin
          rsp_err_q   <= 1'b1;
          rsp_rdata_q <= '0;
        end
      end
    end
  end

  // Strobes exist only in REQ, so every transaction is framed by a
  // strobe-free cycle that lets the slave re-arm its ack.
  assign bus_sel   = in_req;
  assign bus_wen   = in_req &  req_wen_q;
  assign bus_ren   = in_req & ~req_wen_q;
  assign bus_addr  = in_req ? req_addr_q : 32'd0;
  assign bus_width = in_req ? req_width_q[1:0] : 2'b00;
  assign bus_wdata = in_req ? st_rep : 32'd0;

  assign cpu_rsp_valid = (state_q == RESP);
  assign cpu_rsp_rdata = cpu_rsp_valid ? rsp_rdata_q : 32'd0;
  assign cpu_rsp_err   = cpu_rsp_valid & rsp_err_q;

endmodule

// File: tb/tb_dmem_minibus_master.sv
module tb_dmem_minibus_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req_valid;
  logic        cpu_req_ready;
  logic        cpu_req_wen;
  logic [31:0] cpu_req_addr;
  logic [31:0] cpu_req_wdata;
  logic [2:0]  cpu_req_width;
  logic        cpu_rsp_valid;
  logic [31:0] cpu_rsp_rdata;
  logic        cpu_rsp_err;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_wen;
  logic        bus_ren;
  logic [1:0]  bus_width;
  logic        bus_sel;
  logic        bus_ack;
  logic        bus_err;
  logic [31:0] bus_rdata;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  // slave model controls
  int   ack_wait  = 1;
  logic never_ack = 1'b0;
  logic err_mode  = 1'b0;
  int   scnt      = 0;

  logic [31:0] ram [0:255];
  logic [255:0] written = '0;

  dmem_minibus_master #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_req_wen(cpu_req_wen), .cpu_req_addr(cpu_req_addr),
    .cpu_req_wdata(cpu_req_wdata), .cpu_req_width(cpu_req_width),
    .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_rdata(cpu_rsp_rdata),
    .cpu_rsp_err(cpu_rsp_err),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wen(bus_wen),
    .bus_ren(bus_ren), .bus_width(bus_width), .bus_sel(bus_sel),
    .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input logic [7:0] idx);
    case (idx)
      8'h00:   return 32'h00807F00;
      8'h41:   return 32'hDEADBEEF;
      8'h80:   return 32'h11223344;
      default: return {idx, idx, idx, idx};
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [1:0] w, input logic [1:0] alo);
    logic [31:0] r;
    r = old;
    case (w)
      2'b00:   r[8*alo +: 8] = wd[8*alo +: 8];
      2'b01:   r[16*alo[1] +: 16] = wd[16*alo[1] +: 16];
      default: r = wd;
    endcase
    return r;
  endfunction

  assign bus_rdata = written[bus_addr[9:2]] ? ram[bus_addr[9:2]] : init_word(bus_addr[9:2]);
  assign bus_ack   = bus_sel && !never_ack && (scnt == ack_wait);
  assign bus_err   = bus_sel && err_mode && (scnt == ack_wait);

  always @(posedge clk) begin
    scnt <= bus_sel ? scnt + 1 : 0;
    if (bus_sel && bus_wen && bus_ack && !bus_err) begin
      ram[bus_addr[9:2]] <= merge(bus_rdata, bus_wdata, bus_width, bus_addr[1:0]);
      written[bus_addr[9:2]] <= 1'b1;
    end
  end

  // Drives one request and observes it until the response pulse (bounded).
  task automatic run_req(input logic wen, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [2:0] width,
                         output logic got, output int lat, output logic [31:0] rdata,
                         output logic err, output int sels, output int wens,
                         output logic [31:0] first_wdata, output logic [1:0] first_width,
                         output logic strobes, output logic pulse_after);
    int n;
    got = 0; lat = 0; rdata = '0; err = 0; sels = 0; wens = 0;
    first_wdata = '0; first_width = '0; strobes = 0; pulse_after = 0;
    @(negedge clk);
    cpu_req_wen = wen; cpu_req_addr = addr; cpu_req_wdata = wd; cpu_req_width = width;
    cpu_req_valid = 1'b1;
    n = 0;
    while (!cpu_req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    cpu_req_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 1) begin first_wdata = bus_wdata; first_width = bus_width; end
      if (bus_sel) sels++;
      if (bus_wen) wens++;
      if (cpu_rsp_valid) begin
        got = 1; lat = k; rdata = cpu_rsp_rdata; err = cpu_rsp_err;
        strobes = bus_sel | bus_wen | bus_ren;
        break;
      end
    end
    if (got) begin
      @(negedge clk);
      pulse_after = cpu_rsp_valid;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; cpu_req_valid = 0; cpu_req_wen = 0; cpu_req_addr = '0;
    cpu_req_wdata = '0; cpu_req_width = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({cpu_req_ready, cpu_rsp_valid, cpu_rsp_rdata, cpu_rsp_err, bus_addr, bus_wdata,
         bus_wen, bus_ren, bus_width, bus_sel} !== {1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0,
         1'b0, 1'b0, 2'b00, 1'b0}) begin
      bad++;
      $display("FAIL reset_outputs ready=%b rsp_valid=%b sel=%b addr=%h", cpu_req_ready,
               cpu_rsp_valid, bus_sel, bus_addr);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({cpu_req_ready, cpu_rsp_valid, bus_sel} !== 3'b100) begin
      bad++;
      $display("FAIL reset_idle got=%b exp=100", {cpu_req_ready, cpu_rsp_valid, bus_sel});
    end
  endtask

  // Loads against a one-wait slave, byte loads signed/unsigned, and word after store.
  task automatic test_loads;
    logic [31:0] a [4]  = '{32'h104, 32'h2, 32'h2, 32'h0};
    logic [2:0]  w [4]  = '{3'b010, 3'b000, 3'b100, 3'b001};
    logic [31:0] e [4]  = '{32'hDEADBEEF, 32'hFFFFFF80, 32'h00000080, 32'h00007F00};
    logic got, err, stb, pa; int lat, sels, wens; logic [31:0] rd, fw; logic [1:0] fwid;
    exp_t x;
    ack_wait = 1;
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{rdata: e[i], err: 1'b0, lat: 3});
      run_req(1'b0, a[i], 32'd0, w[i], got, lat, rd, err, sels, wens, fw, fwid, stb, pa);
      x = sb.pop_front();
      total++;
      if (!got || lat != x.lat) begin
        bad++; $display("FAIL load%0d_latency got=%0d exp=%0d (rsp=%b)", i, lat, x.lat, got);
      end
      total++;
      if ({rd, err} !== {x.rdata, x.err}) begin
        bad++; $display("FAIL load%0d_data got=%h/%b exp=%h/%b", i, rd, err, x.rdata, x.err);
      end
    end
  endtask

  task automatic test_store_byte;
    logic got, err, stb, pa; int lat, sels, wens; logic [31:0] rd, fw; logic [1:0] fwid;
    exp_t x;
    ack_wait = 1;
    sb.push_back('{rdata: 32'd0, err: 1'b0, lat: 3});
    run_req(1'b1, 32'h203, 32'h0000005A, 3'b000, got, lat, rd, err, sels, wens, fw, fwid, stb, pa);
    x = sb.pop_front();
    total++;
    if (fw !== 32'h5A5A5A5A || fwid !== 2'b00) begin
      bad++; $display("FAIL store_lanes got=%h/%b exp=5a5a5a5a/00", fw, fwid);
    end
    total++;
    if (wens != 2) begin
      bad++; $display("FAIL store_wen_hold got=%0d exp=2", wens);
    end
    total++;
    if (!got || lat != x.lat || {rd, err} !== {x.rdata, x.err} || pa !== 1'b0) begin
      bad++; $display("FAIL store_rsp got=%b lat=%0d data=%h err=%b again=%b", got, lat, rd, err, pa);
    end
    sb.push_back('{rdata: 32'h5A223344, err: 1'b0, lat: 3});
    run_req(1'b0, 32'h200, 32'd0, 3'b010, got, lat, rd, err, sels, wens, fw, fwid, stb, pa);
    x = sb.pop_front();
    total++;
    if (!got || {rd, err} !== {x.rdata, x.err}) begin
      bad++; $display("FAIL store_readback got=%h exp=%h", rd, x.rdata);
    end
  endtask

  task automatic test_misaligned;
    logic [31:0] a [3] = '{32'h1, 32'h102, 32'h100};
    logic [2:0]  w [3] = '{3'b001, 3'b010, 3'b011};
    logic got, err, stb, pa; int lat, sels, wens; logic [31:0] rd, fw; logic [1:0] fwid;
    exp_t x;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{rdata: 32'd0, err: 1'b1, lat: 1});
      run_req(1'b0, a[i], 32'd0, w[i], got, lat, rd, err, sels, wens, fw, fwid, stb, pa);
      x = sb.pop_front();
      total++;
      if (!got || lat != x.lat || sels != 0 || {rd, err} !== {x.rdata, x.err}) begin
        bad++; $display("FAIL misaligned%0d got lat=%0d sels=%0d data=%h err=%b exp lat=1 sels=0 err=1",
                        i, lat, sels, rd, err);
      end
    end
  endtask

  task automatic test_timeout;
    logic got, err, stb, pa; int lat, sels, wens; logic [31:0] rd, fw; logic [1:0] fwid;
    exp_t x;
    never_ack = 1'b1;
    sb.push_back('{rdata: 32'd0, err: 1'b1, lat: 5});
    run_req(1'b0, 32'h104, 32'd0, 3'b010, got, lat, rd, err, sels, wens, fw, fwid, stb, pa);
    x = sb.pop_front();
    never_ack = 1'b0;
    total++;
    if (sels != 4) begin
      bad++; $display("FAIL timeout_req_cycles got=%0d exp=4", sels);
    end
    total++;
    if (!got || lat != x.lat || {rd, err} !== {x.rdata, x.err} || stb !== 1'b0) begin
      bad++; $display("FAIL timeout_rsp got=%b lat=%0d err=%b strobes=%b exp lat=5 err=1", got, lat, err, stb);
    end
  endtask

  task automatic test_priority;
    logic got, err, stb, pa; int lat, sels, wens; logic [31:0] rd, fw; logic [1:0] fwid;
    exp_t x;
    ack_wait = 1; err_mode = 1'b1;
    sb.push_back('{rdata: 32'd0, err: 1'b1, lat: 3});
    run_req(1'b0, 32'h104, 32'd0, 3'b010, got, lat, rd, err, sels, wens, fw, fwid, stb, pa);
    x = sb.pop_front();
    err_mode = 1'b0;
    total++;
    if (!got || lat != x.lat || {rd, err} !== {x.rdata, x.err}) begin
      bad++; $display("FAIL err_over_ack got=%h/%b lat=%0d exp=%h/%b", rd, err, lat, x.rdata, x.err);
    end
    ack_wait = 3;
    sb.push_back('{rdata: 32'hDEADBEEF, err: 1'b0, lat: 5});
    run_req(1'b0, 32'h104, 32'd0, 3'b010, got, lat, rd, err, sels, wens, fw, fwid, stb, pa);
    x = sb.pop_front();
    ack_wait = 1;
    total++;
    if (!got || lat != x.lat || {rd, err} !== {x.rdata, x.err}) begin
      bad++; $display("FAIL ack_over_timeout got=%h/%b lat=%0d exp=%h/%b", rd, err, lat, x.rdata, x.err);
    end
  endtask

  task automatic test_reset_mid;
    logic got, err, stb, pa; int lat, sels, wens; logic [31:0] rd, fw; logic [1:0] fwid;
    logic seen; exp_t x; int n;
    never_ack = 1'b1;
    @(negedge clk);
    cpu_req_wen = 1'b1; cpu_req_addr = 32'h40; cpu_req_wdata = 32'h12345678;
    cpu_req_width = 3'b010; cpu_req_valid = 1'b1;
    n = 0;
    while (!cpu_req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    cpu_req_valid = 1'b0;
    total++;
    if (bus_sel !== 1'b1) begin
      bad++; $display("FAIL reset_mid_in_req got sel=%b exp=1", bus_sel);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({bus_sel, bus_wen, bus_ren, bus_addr, bus_wdata, bus_width, cpu_req_ready, cpu_rsp_valid}
        !== {3'b000, 32'd0, 32'd0, 2'b00, 1'b1, 1'b0}) begin
      bad++; $display("FAIL reset_mid_outputs sel=%b wen=%b addr=%h wd=%h ready=%b rsp=%b",
                      bus_sel, bus_wen, bus_addr, bus_wdata, cpu_req_ready, cpu_rsp_valid);
    end
    never_ack = 1'b0;
    seen = 1'b0;
    repeat (3) begin @(negedge clk); if (cpu_rsp_valid) seen = 1'b1; end
    total++;
    if (seen !== 1'b0) begin
      bad++; $display("FAIL reset_mid_no_rsp got=%b exp=0", seen);
    end
    total++;
    if (written[8'h10] !== 1'b0) begin
      bad++; $display("FAIL reset_mid_no_write got=%b exp=0", written[8'h10]);
    end
    sb.push_back('{rdata: 32'hDEADBEEF, err: 1'b0, lat: 3});
    run_req(1'b0, 32'h104, 32'd0, 3'b010, got, lat, rd, err, sels, wens, fw, fwid, stb, pa);
    x = sb.pop_front();
    total++;
    if (!got || lat != x.lat || {rd, err} !== {x.rdata, x.err}) begin
      bad++; $display("FAIL reset_mid_recover got=%h/%b lat=%0d exp=%h", rd, err, lat, x.rdata);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a [4] = '{32'h104, 32'h0, 32'h2, 32'h1};
    logic [2:0]  w [4] = '{3'b010, 3'b001, 3'b101, 3'b000};
    logic [31:0] e [4] = '{32'hDEADBEEF, 32'h00007F00, 32'h00000080, 32'h0000007F};
    int acc [4];
    ack_wait = 1;
    for (int i = 0; i < 4; i++) sb.push_back('{rdata: e[i], err: 1'b0, lat: 3});
    fork
      begin
        int n;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
          cpu_req_wen = 1'b0; cpu_req_addr = a[i]; cpu_req_width = w[i]; cpu_req_valid = 1'b1;
          n = 0;
          while (!cpu_req_ready && n < 20) begin @(negedge clk); n++; end
          @(posedge clk);
          @(negedge clk);
          acc[i] = cyc;
        end
        cpu_req_valid = 1'b0;
      end
      begin
        exp_t x; int k;
        for (int i = 0; i < 4; i++) begin
          k = 0;
          @(negedge clk);
          while (!cpu_rsp_valid && k < 30) begin @(negedge clk); k++; end
          x = sb.pop_front();
          total++;
          if (!cpu_rsp_valid || {cpu_rsp_rdata, cpu_rsp_err} !== {x.rdata, x.err}) begin
            bad++; $display("FAIL b2b_rsp%0d got=%h/%b valid=%b exp=%h/%b", i, cpu_rsp_rdata,
                            cpu_rsp_err, cpu_rsp_valid, x.rdata, x.err);
          end
        end
      end
    join
    for (int i = 1; i < 4; i++) begin
      total++;
      if (acc[i] - acc[i-1] != 3) begin
        bad++; $display("FAIL b2b_interval%0d got=%0d exp=3", i, acc[i] - acc[i-1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_store_byte();
    test_misaligned();
    test_timeout();
    test_priority();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
